seq_restoring_div: RTL
======================

SEQ_RESTORING_DIV -- requirements
Module: seq_restoring_div

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter: WIDTH, 32, operand and result width in bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request pulse; sampled only while busy=0.
REQ-006 dividend  input  WIDTH  numerator; captured on acceptance.
REQ-007 divisor  input  WIDTH  denominator; captured on acceptance.
REQ-008 busy  output  1  high while the block is computing; new requests are ignored.
REQ-009 done  output  1  single-cycle pulse marking valid results.
REQ-010 quotient  output  WIDTH  registered quotient.
REQ-011 remainder  output  WIDTH  registered remainder.
REQ-012 div_by_zero  output  1  registered flag: last accepted divisor was 0.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE. busy SHALL be 1 only in RUN, and done SHALL be 1 only in DONE.
REQ-014 Acceptance: on a clock edge with start=1 in IDLE or DONE, the block SHALL latch dividend and divisor and clear the iteration counter.
REQ-015 If the accepted divisor is nonzero, the block SHALL go to RUN. If it is zero, the block SHALL go directly to DONE.
REQ-016 RUN SHALL perform one restoring step per clock:
- shift {partial remainder, dividend} left by 1;
- trial-subtract the divisor using a WIDTH+1-bit subtractor;
- if the result is non-negative, keep it and set quotient bit = 1;
- otherwise restore the partial remainder and set quotient bit = 0.
REQ-017 RUN SHALL last exactly WIDTH cycles. After the WIDTH-th iteration edge, the FSM SHALL enter DONE and register quotient and remainder at the same edge.
REQ-018 Latency: done SHALL be high in the cycle beginning WIDTH+1 edges after the acceptance edge (33 for WIDTH=32). For a zero divisor, done SHALL be high 1 edge after acceptance.
REQ-019 DONE SHALL last exactly one cycle. The next state SHALL be RUN, or DONE for a zero divisor, if start=1 (back-to-back operation); otherwise it SHALL be IDLE.
REQ-020 Divide-by-zero result: quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-021 div_by_zero SHALL clear on the next completion whose divisor is nonzero.
REQ-022 start asserted while busy=1 SHALL be ignored with no effect. Changes on dividend and divisor during RUN SHALL not affect the result.
REQ-023 quotient, remainder and div_by_zero SHALL hold their values between done pulses. They SHALL update only at the edge entering DONE.
REQ-024 dividend < divisor SHALL yield quotient = 0 and remainder = dividend. dividend = 0 SHALL yield quotient = 0 and remainder = 0.

Reset
REQ-025 rst_n=0 SHALL immediately force, regardless of clk:
- state = IDLE;
- busy = 0, done = 0;
- quotient = 0, remainder = 0, div_by_zero = 0;
- iteration counter = 0.
REQ-026 Reset asserted during RUN SHALL abort the operation with no done pulse. The first request after release SHALL complete normally.
REQ-027 start SHALL be ignored while rst_n=0. The first edge after rst_n rises MAY accept start.

Configuration
REQ-028 Macro DIV_SIGNED_EN: when defined, operands SHALL be treated as two's complement.
- Magnitudes are divided by the REQ-016 engine.
- quotient is negated if the operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
- Sign fix-up SHALL be applied at the edge entering DONE and SHALL add no cycles.
- Divide-by-zero behaviour SHALL match REQ-020.
- Most-negative value / -1 SHALL return quotient = 0x80000000 (WIDTH=32) and remainder = 0.
REQ-029 When DIV_SIGNED_EN is not defined, all operands and results SHALL be unsigned and the block SHALL contain no sign logic.

Verification
REQ-030 dividend=100, divisor=7, start for 1 cycle -> busy high for 32 cycles, then done for 1 cycle with quotient=14, remainder=2, div_by_zero=0.
REQ-031 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0. Then 5 / 0 -> done 1 cycle after acceptance, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-032 start=1 held continuously with 1000/10, dividend switched to 9 during RUN -> results 100/0. Back-to-back acceptance in the DONE cycle SHALL give the second done exactly 33 cycles after the first.
REQ-033 rst_n pulled low at RUN iteration 10 of 50/3 -> all outputs 0 immediately and no done. A new 50/3 after release -> quotient=16, remainder=2.
REQ-034 DIV_SIGNED_EN defined: -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. 7 / -2 -> quotient=0xFFFFFFFD, remainder=1. 0x80000000 / -1 -> quotient=0x80000000, remainder=0.

Source files
------------

// File: rtl/seq_restoring_div.sv
// seq_restoring_div: multi-cycle restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (truncation toward zero).
module seq_restoring_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d, dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
  logic dbz_q, dbz_d;
  logic [WIDTH:0] shifted, diff;
  logic ge, accept, last;
  logic [WIDTH-1:0] step_rem, step_quo, a_mag, b_mag, fin_quo, fin_rem;
`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d, rneg_q, rneg_d;
  assign a_mag   = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag   = divisor[WIDTH-1] ? -divisor : divisor;
  assign fin_quo = qneg_q ? -step_quo : step_quo;
  assign fin_rem = rneg_q ? -step_rem : step_rem;
`else
  assign a_mag   = dividend;
  assign b_mag   = divisor;
  assign fin_quo = step_quo;
  assign fin_rem = step_rem;
`endif
  always_comb begin
    accept   = start && state_q != RUN;
    shifted  = {prem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    ge       = !diff[WIDTH];
    step_rem = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    step_quo = {dvd_q[WIDTH-2:0], ge};
    last     = cnt_q == CW'(WIDTH - 1);
    state_d  = state_q;
    cnt_d    = cnt_q;
    prem_d   = prem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
`ifdef DIV_SIGNED_EN
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
`endif
    if (accept) begin
      dvd_d   = a_mag;
      dvs_d   = b_mag;
      prem_d  = '0;
      cnt_d   = '0;
      state_d = divisor == '0 ? DONE : RUN;
`ifdef DIV_SIGNED_EN
      qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg_d  = dividend[WIDTH-1];
`endif
      // zero divisor skips RUN, so its results are registered right here
      if (divisor == '0) begin
        quo_d = '1;
        rem_d = dividend;
        dbz_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      prem_d = step_rem;
      dvd_d  = step_quo;
      cnt_d  = cnt_q + 1'b1;
      if (last) begin
        state_d = DONE;
        quo_d   = fin_quo;
        rem_d   = fin_rem;
        dbz_d   = 1'b0;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end
  assign busy        = state_q == RUN;
  assign done        = state_q == DONE;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule
